// File: rtl/sbox_cfg_pkg.sv
// Shared constants, types and slot-to-pin mapping for the switch-box config loader.
package sbox_cfg_pkg;

   localparam int unsigned N_TB       = 5;
   localparam int unsigned N_LR       = 4;
   localparam int unsigned CW         = 6;
   localparam int unsigned N_SLOTS    = 2 * N_TB + 2 * N_LR;
   localparam int unsigned FRAME_BITS = N_SLOTS * CW;
   localparam int unsigned SLOT_W     = $clog2(N_SLOTS);

   localparam logic [2:0] SIDE_NONE   = 3'd0;
   localparam logic [2:0] SIDE_TOP    = 3'd1;
   localparam logic [2:0] SIDE_RIGHT  = 3'd2;
   localparam logic [2:0] SIDE_BOTTOM = 3'd3;
   localparam logic [2:0] SIDE_LEFT   = 3'd4;

   localparam logic [2:0] IDX_TB_LIM = 3'(N_TB);
   localparam logic [2:0] IDX_LR_LIM = 3'(N_LR);
   localparam logic [2:0] BIT_LAST   = 3'(CW - 1);

   localparam logic [SLOT_W-1:0] SLOT_BOTTOM0 = SLOT_W'(N_TB);
   localparam logic [SLOT_W-1:0] SLOT_LEFT0   = SLOT_W'(2 * N_TB);
   localparam logic [SLOT_W-1:0] SLOT_RIGHT0  = SLOT_W'(2 * N_TB + N_LR);
   localparam logic [SLOT_W-1:0] SLOT_LAST    = SLOT_W'(N_SLOTS - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StCheck, StCommit} state_e;

   typedef struct packed {
      logic [2:0] side;
      logic [2:0] idx;
   } pin_t;

   // Slot order: top[0..N_TB-1], bottom[..], left[0..N_LR-1], right[..]
   function automatic pin_t slot_side_idx(input logic [SLOT_W-1:0] slot);
      pin_t p;
      if (slot < SLOT_BOTTOM0) begin
         p.side = SIDE_TOP;
         p.idx  = 3'(slot);
      end else if (slot < SLOT_LEFT0) begin
         p.side = SIDE_BOTTOM;
         p.idx  = 3'(slot - SLOT_BOTTOM0);
      end else if (slot < SLOT_RIGHT0) begin
         p.side = SIDE_LEFT;
         p.idx  = 3'(slot - SLOT_LEFT0);
      end else begin
         p.side = SIDE_RIGHT;
         p.idx  = 3'(slot - SLOT_RIGHT0);
      end
      return p;
   endfunction

endpackage

// File: rtl/sbox_cfg_word_check.sv
// Combinational validity check of one routing word against the slot it drives.
module sbox_cfg_word_check
   import sbox_cfg_pkg::*;
(
   input  logic [CW-1:0]     word_i,
   input  logic [SLOT_W-1:0] slot_i,
   output logic              valid_o
);

   logic [2:0] side;
   logic [2:0] idx;
   pin_t       own;

   assign side = word_i[2:0];
   assign idx  = word_i[5:3];
   assign own  = slot_side_idx(slot_i);

   always_comb begin
      valid_o = 1'b1;
      case (side)
         SIDE_NONE:               valid_o = 1'b1;
         SIDE_TOP, SIDE_BOTTOM:   valid_o = (idx < IDX_TB_LIM);
         SIDE_RIGHT, SIDE_LEFT:   valid_o = (idx < IDX_LR_LIM);
         default:                 valid_o = 1'b0;
      endcase
      // A pin may not source itself; hi-Z words carry no index
      if (side != SIDE_NONE && side == own.side && idx == own.idx) begin
         valid_o = 1'b0;
      end
   end

endmodule

// File: rtl/switchbox_cfg_loader.sv
// Serial config loader: shifts a frame into a shadow store, validates each slot,
// then commits the whole frame to the active routing bus.
module switchbox_cfg_loader
   import sbox_cfg_pkg::*;
(
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cfg_start_i,
   input  logic                  cfg_clear_i,
   input  logic                  cfg_valid_i,
   input  logic                  cfg_bit_i,
   output logic                  cfg_ready_o,
   output logic                  cfg_busy_o,
   output logic                  cfg_done_o,
   output logic                  cfg_err_o,
   output logic [SLOT_W-1:0]     cfg_err_slot_o,
   output logic [FRAME_BITS-1:0] cfg_active_o
);

   state_e                  state_q, state_d;
   logic [2:0]              bit_cnt_q, bit_cnt_d;
   logic [SLOT_W-1:0]       slot_q, slot_d;
   logic [CW-2:0]           word_q, word_d;
   logic [FRAME_BITS-1:0]   shadow_q, shadow_d;
   logic [FRAME_BITS-1:0]   active_q, active_d;
   logic                    done_q, done_d;
   logic                    err_q, err_d;
   logic [SLOT_W-1:0]       err_slot_q, err_slot_d;
   logic [CW-1:0]           chk_word;
   logic                    chk_ok;

   assign chk_word = shadow_q[int'(slot_q) * CW +: CW];

   sbox_cfg_word_check u_word_check (
      .word_i  (chk_word),
      .slot_i  (slot_q),
      .valid_o (chk_ok)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         slot_q     <= '0;
         word_q     <= '0;
         shadow_q   <= '0;
         active_q   <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         err_slot_q <= '0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         slot_q     <= slot_d;
         word_q     <= word_d;
         shadow_q   <= shadow_d;
         active_q   <= active_d;
         done_q     <= done_d;
         err_q      <= err_d;
         err_slot_q <= err_slot_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      slot_d     = slot_q;
      word_d     = word_q;
      shadow_d   = shadow_q;
      active_d   = active_q;
      done_d     = 1'b0;
      err_d      = err_q;
      err_slot_d = err_slot_q;
      unique case (state_q)
         StIdle: begin
            if (cfg_clear_i) begin
               active_d = '0;
            end else if (cfg_start_i) begin
               state_d   = StLoad;
               bit_cnt_d = '0;
               slot_d    = '0;
               err_d     = 1'b0;
            end
         end
         StLoad: begin
            if (cfg_valid_i) begin
               word_d = {word_q[CW-3:0], cfg_bit_i};
               if (bit_cnt_q == BIT_LAST) begin
                  bit_cnt_d = '0;
                  // Completed words enter at the top so slot 0 ends at the bottom
                  shadow_d  = {word_q, cfg_bit_i, shadow_q[FRAME_BITS-1:CW]};
                  if (slot_q == SLOT_LAST) begin
                     state_d = StCheck;
                     slot_d  = '0;
                  end else begin
                     slot_d = slot_q + SLOT_W'(1);
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
               end
            end
         end
         StCheck: begin
            if (!chk_ok) begin
               err_d      = 1'b1;
               err_slot_d = slot_q;
               state_d    = StIdle;
            end else if (slot_q == SLOT_LAST) begin
               state_d = StCommit;
            end else begin
               slot_d = slot_q + SLOT_W'(1);
            end
         end
         StCommit: begin
            active_d = shadow_q;
            done_d   = 1'b1;
            state_d  = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign cfg_ready_o    = (state_q == StLoad);
   assign cfg_busy_o     = (state_q != StIdle);
   assign cfg_done_o     = done_q;
   assign cfg_err_o      = err_q;
   assign cfg_err_slot_o = err_slot_q;
   assign cfg_active_o   = active_q;

endmodule

// File: tb/tb_switchbox_cfg_loader.sv
// Scoreboard bench: frame drivers queue the expected commit/reject event, a monitor checks it.
module tb_switchbox_cfg_loader;
   import sbox_cfg_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst, start, clear, valid, bitv;
   logic                  ready, busy, done, err;
   logic [SLOT_W-1:0]     err_slot;
   logic [FRAME_BITS-1:0] active;

   switchbox_cfg_loader dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .cfg_start_i    (start),
      .cfg_clear_i    (clear),
      .cfg_valid_i    (valid),
      .cfg_bit_i      (bitv),
      .cfg_ready_o    (ready),
      .cfg_busy_o     (busy),
      .cfg_done_o     (done),
      .cfg_err_o      (err),
      .cfg_err_slot_o (err_slot),
      .cfg_active_o   (active)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit                    is_err;
      logic [FRAME_BITS-1:0] active;
      int                    slot;
      int                    lat;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   n_chk = 0;
   int   n_pass = 0;
   int   cyc = 0;
   int   acc_cyc = 0;
   logic err_prev = 1'b0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Edge counter; acc_cyc holds the edge index of the most recent accepted bit
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (valid && ready) acc_cyc <= cyc;
   end

   always @(negedge clk) begin
      if (!rst && (done || (err && !err_prev))) begin
         if (sb.size() == 0) begin
            chk("unexpected event", {done, err}, 2'b00);
         end else begin
            e = sb.pop_front();
            chk("event kind", err, e.is_err);
            chk("active", active, e.active);
            if (e.is_err) chk("err_slot", err_slot, e.slot);
            else chk("err low on commit", err, 1'b0);
            chk("latency", cyc - acc_cyc, e.lat);
            chk("busy after event", busy, 1'b0);
         end
      end
      err_prev <= err;
   end

   task automatic send_frame(input logic [FRAME_BITS-1:0] f, input bit gaps, input bit pokes,
                             input int stop_at);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int i = 0; i < FRAME_BITS && i < stop_at; i++) begin
         int s;
         int b;
         int guard;
         s     = i / CW;
         b     = CW - 1 - (i % CW);
         guard = 0;
         bitv  = f[s * CW + b];
         while (gaps && $urandom_range(1, 0) == 0 && guard < 8) begin
            valid = 1'b0;
            start = pokes ? 1'($urandom_range(1, 0)) : 1'b0;
            @(posedge clk); #1;
            guard++;
         end
         valid = 1'b1;
         start = pokes ? 1'($urandom_range(1, 0)) : 1'b0;
         @(posedge clk); #1;
      end
      valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 60) begin
         @(posedge clk);
         g++;
      end
      #1;
      chk("scoreboard drained", sb.size(), 0);
      repeat (2) @(posedge clk);
      #1;
   endtask

   logic [FRAME_BITS-1:0] fa, fb, fc, fd, fe;

   initial begin
      fa = '0; fa[0 * CW +: CW] = 6'b011_100;               // top0 <- left3
      fb = fa; fb[7 * CW +: CW] = 6'b100_010;               // right idx 4: out of range
      fc = '0; fc[10 * CW +: CW] = 6'b000_100;              // left0 <- left0: self-loop
      fd = '0; fd[0 * CW +: CW] = 6'b000_101;               // side code 5
      fe = '0;
      fe[0 * CW +: CW]  = 6'b011_100;                       // top0 <- left3
      fe[3 * CW +: CW]  = 6'b111_000;                       // hi-Z, index ignored
      fe[5 * CW +: CW]  = 6'b100_001;                       // bottom0 <- top4
      fe[14 * CW +: CW] = 6'b011_100;                       // right0 <- left3
      fe[17 * CW +: CW] = 6'b000_011;                       // right3 <- bottom0

      rst = 1'b1; start = 1'b0; clear = 1'b0; valid = 1'b0; bitv = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("reset active", active, '0);
      chk("reset busy", busy, 1'b0);
      chk("reset done", done, 1'b0);
      chk("reset err", err, 1'b0);
      chk("reset err_slot", err_slot, '0);
      chk("reset ready", ready, 1'b0);

      sb.push_back('{1'b0, fa, 0, 20});
      send_frame(fa, 1'b0, 1'b0, FRAME_BITS);
      wait_drain();

      sb.push_back('{1'b1, fa, 7, 9});
      send_frame(fb, 1'b0, 1'b0, FRAME_BITS);
      wait_drain();
      chk("err sticky", err, 1'b1);
      chk("err_slot held", err_slot, 5'd7);

      sb.push_back('{1'b1, fa, 10, 12});
      send_frame(fc, 1'b0, 1'b0, FRAME_BITS);
      wait_drain();

      sb.push_back('{1'b1, fa, 0, 2});
      send_frame(fd, 1'b0, 1'b0, FRAME_BITS);
      wait_drain();

      sb.push_back('{1'b0, fe, 0, 20});
      send_frame(fe, 1'b1, 1'b1, FRAME_BITS);
      wait_drain();

      start = 1'b1; clear = 1'b1;
      @(posedge clk); #1;
      start = 1'b0; clear = 1'b0;
      chk("clear active", active, '0);
      chk("clear beats start", busy, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      chk("idle after clear", ready, 1'b0);

      sb.push_back('{1'b0, fa, 0, 20});
      send_frame(fa, 1'b0, 1'b0, FRAME_BITS);
      wait_drain();

      send_frame(fa, 1'b0, 1'b0, 50);
      chk("mid-load busy", busy, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst active", active, '0);
      chk("rst busy", busy, 1'b0);
      chk("rst ready", ready, 1'b0);
      chk("rst err", err, 1'b0);
      repeat (30) @(posedge clk);
      #1;
      chk("no late event", sb.size(), 0);
      chk("still idle", busy, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
